// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART-side bundle of the round-robin UART transmit arbiter.
// slave  : seen from the arbiter (requests and txrdy in, strobes and data out).
// master : seen from the requesters and the UART core driving the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 txrdy;
  logic [7:0]           tx_data;
  logic                 tx_load;
  logic                 timeout_err;

  modport slave (
    input  req_valid, req_data, req_last, txrdy,
    output req_ready, grant, busy, tx_data, tx_load, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last, txrdy,
    input  req_ready, grant, busy, tx_data, tx_load, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one CoreUARTapb transmit path.
// A granted requester keeps the UART until it sends a byte flagged req_last.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN -- forced release of an owner
// that holds the grant without presenting data for TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT >= (1 << TO_W)) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT < 2**TO_W");
  end

  typedef enum logic [1:0] {IDLE, OWN, SETTLE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               release_q, release_d;
  logic               blank_q, blank_d;
  logic               tx_load_q, tx_load_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [NUM_REQ-1:0] owner_oh;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   scan_idx;
  logic               scan_found;
  logic               owner_valid;
  logic               owner_last;
  logic [7:0]         owner_data;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               to_err_q, to_err_d;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  assign owner_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign owner_valid = bus.req_valid[owner_q];
  assign owner_last  = bus.req_last[owner_q];
  assign owner_data  = bus.req_data[{owner_q, 3'b000} +: 8];

  assign bus.grant     = (state_q != IDLE) ? owner_oh : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.req_ready = req_ready_c;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_load   = tx_load_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign bus.timeout_err = to_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // Pick the first valid requester scanning upward from rr_ptr with wrap.
  always_comb begin
    winner     = rr_ptr_q;
    scan_idx   = rr_ptr_q;
    scan_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!scan_found && bus.req_valid[scan_idx]) begin
        winner     = scan_idx;
        scan_found = 1'b1;
      end
      scan_idx = ptr_inc(scan_idx);
    end
  end

  // Next-state and accept logic. The UART reflects a load on txrdy only from
  // the second cycle after tx_load, so the first OWN cycle after SETTLE is
  // blanked; this gives the 3-clk byte period.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    release_d   = release_q;
    blank_d     = 1'b0;
    tx_load_d   = 1'b0;
    tx_data_d   = tx_data_q;
    req_ready_c = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_cnt_d    = '0;
    to_err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          owner_d   = winner;
          release_d = 1'b0;
          state_d   = OWN;
        end
      end
      OWN: begin
        if (!blank_q && bus.txrdy && owner_valid) begin
          req_ready_c = owner_oh;
          tx_data_d   = owner_data;
          tx_load_d   = 1'b1;
          release_d   = owner_last;
          state_d     = SETTLE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (owner_valid) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
          rr_ptr_d = ptr_inc(owner_q);
          to_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      SETTLE: begin
        if (release_q) begin
          rr_ptr_d = ptr_inc(owner_q);
          state_d  = IDLE;
        end else begin
          blank_d  = 1'b1;
          state_d  = OWN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and output registers; reset aborts any message in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      release_q <= 1'b0;
      blank_q   <= 1'b0;
      tx_load_q <= 1'b0;
      tx_data_q <= 8'h00;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q  <= '0;
      to_err_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      release_q <= release_d;
      blank_q   <= blank_d;
      tx_load_q <= tx_load_d;
      tx_data_q <= tx_data_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      to_err_q  <= to_err_d;
`endif
    end
  end

endmodule
